// File: rtl/rob_pkg.sv
// Shared ROB sizing and types; the register file and instruction queue
// import rob_tag_t from here so producer tags agree across the core.
package rob_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_TAG_W = 3;
    localparam int XLEN      = 32;

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;
    typedef logic [ROB_TAG_W:0]   rob_count_t;

    typedef struct packed {
        logic            busy;
        logic            ready;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_buffer_if.sv
// Dispatch, CDB, commit and operand-query signals of the reorder buffer.
// The master side is dispatch/CDB/regfile; the slave side is the ROB itself.
interface rob_commit_buffer_if;
    import rob_pkg::*;

    logic            flush;
    logic            alloc_req;
    logic [4:0]      alloc_rd;
    logic            alloc_ready;
    rob_tag_t        alloc_tag;
    logic            cdb_valid;
    rob_tag_t        cdb_tag;
    logic [XLEN-1:0] cdb_data;
    logic            commit_load;
    logic [4:0]      commit_dest;
    logic [XLEN-1:0] commit_data;
    rob_tag_t        commit_tag;
    rob_tag_t        query_tag_a;
    rob_tag_t        query_tag_b;
    logic            query_ready_a;
    logic            query_ready_b;
    logic [XLEN-1:0] query_data_a;
    logic [XLEN-1:0] query_data_b;
    logic            empty;
    logic            full;
    rob_count_t      count;

    modport master (
        output flush, alloc_req, alloc_rd, cdb_valid, cdb_tag, cdb_data,
               query_tag_a, query_tag_b,
        input  alloc_ready, alloc_tag, commit_load, commit_dest, commit_data,
               commit_tag, query_ready_a, query_ready_b, query_data_a,
               query_data_b, empty, full, count
    );

    modport slave (
        input  flush, alloc_req, alloc_rd, cdb_valid, cdb_tag, cdb_data,
               query_tag_a, query_tag_b,
        output alloc_ready, alloc_tag, commit_load, commit_dest, commit_data,
               commit_tag, query_ready_a, query_ready_b, query_data_a,
               query_data_b, empty, full, count
    );

endinterface

// File: rtl/rob_commit_buffer.sv
// 8-entry in-order reorder buffer: tag allocation, CDB capture, one in-order
// commit per cycle into the register file, and tag-indexed operand bypass.
module rob_commit_buffer
    import rob_pkg::*;
(
    input logic                clk,
    input logic                rst,
    rob_commit_buffer_if.slave bus
);

    rob_entry_t entries_q [ROB_DEPTH];
    rob_entry_t entries_d [ROB_DEPTH];
    rob_tag_t   head_q, head_d;
    rob_tag_t   tail_q, tail_d;
    rob_count_t count_q, count_d;

    rob_entry_t head_entry;
    logic       full_w;
    logic       alloc_fire;
    logic       commit_fire;
    logic       cdb_take;
    logic       hit_a, hit_b;

    assign head_entry  = entries_q[head_q];
    assign full_w      = (count_q == rob_count_t'(ROB_DEPTH));
    assign alloc_fire  = bus.alloc_req && !full_w;
    assign commit_fire = head_entry.busy && head_entry.ready;
    // A result aimed at the entry retiring this edge would resurrect a freed slot.
    assign cdb_take    = bus.cdb_valid && entries_q[bus.cdb_tag].busy &&
                         !(commit_fire && (bus.cdb_tag == head_q));

    assign bus.alloc_ready = !full_w;
    assign bus.alloc_tag   = tail_q;
    assign bus.empty       = (count_q == '0);
    assign bus.full        = full_w;
    assign bus.count       = count_q;

    assign bus.commit_load = commit_fire;
    assign bus.commit_dest = head_entry.busy ? head_entry.rd   : 5'd0;
    assign bus.commit_data = head_entry.busy ? head_entry.data : '0;
    assign bus.commit_tag  = head_entry.busy ? head_q          : '0;

    // Operand lookup forwards a same-cycle CDB broadcast ahead of the stored value.
    assign hit_a = bus.cdb_valid && (bus.cdb_tag == bus.query_tag_a);
    assign hit_b = bus.cdb_valid && (bus.cdb_tag == bus.query_tag_b);

    assign bus.query_ready_a = entries_q[bus.query_tag_a].busy &&
                               (entries_q[bus.query_tag_a].ready || hit_a);
    assign bus.query_ready_b = entries_q[bus.query_tag_b].busy &&
                               (entries_q[bus.query_tag_b].ready || hit_b);
    assign bus.query_data_a  = hit_a ? bus.cdb_data : entries_q[bus.query_tag_a].data;
    assign bus.query_data_b  = hit_b ? bus.cdb_data : entries_q[bus.query_tag_b].data;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (bus.flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_d[i].busy  = 1'b0;
                entries_d[i].ready = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_take) begin
                entries_d[bus.cdb_tag].ready = 1'b1;
                entries_d[bus.cdb_tag].data  = bus.cdb_data;
            end
            if (commit_fire) begin
                entries_d[head_q].busy  = 1'b0;
                entries_d[head_q].ready = 1'b0;
                head_d = head_q + 1'b1;
            end
            // Allocation never targets the head being freed: that would require full.
            if (alloc_fire) begin
                entries_d[tail_q].busy  = 1'b1;
                entries_d[tail_q].ready = 1'b0;
                entries_d[tail_q].rd    = bus.alloc_rd;
                entries_d[tail_q].data  = '0;
                tail_d = tail_q + 1'b1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Flushing while the head retires would drop an architecturally visible write.
    flushCommitExclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.flush && commit_fire));

endmodule

// File: tb/tb_rob_commit_buffer.sv
// Directed and randomized checks of rob_commit_buffer against a program-order
// queue model of the reorder buffer.
module tb_rob_commit_buffer;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rob_commit_buffer_if bus();

    rob_commit_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: live instructions in program order, each tagged with its slot.
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          ready;
        logic [31:0] data;
    } modelEntry_t;

    modelEntry_t modelQ[$];
    int          modelTail;

    task automatic checkVal(input string name, input logic [31:0] observed,
                            input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fl, input logic req, input logic [4:0] rd,
                                 input logic cv, input logic [2:0] ct, input logic [31:0] cd,
                                 input logic [2:0] qa, input logic [2:0] qb);
        bus.flush       = fl;
        bus.alloc_req   = req;
        bus.alloc_rd    = rd;
        bus.cdb_valid   = cv;
        bus.cdb_tag     = ct;
        bus.cdb_data    = cd;
        bus.query_tag_a = qa;
        bus.query_tag_b = qb;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd1);
    endtask

    function automatic modelEntry_t modelHead();
        modelEntry_t h;
        h = '{tag: 0, rd: 5'd0, ready: 1'b0, data: 32'd0};
        if (modelQ.size() > 0) h = modelQ[0];
        return h;
    endfunction

    task automatic modelQuery(input logic [2:0] t, output logic rdy, output logic [31:0] dat);
        logic hit;
        rdy = 1'b0;
        dat = 32'd0;
        hit = bus.cdb_valid && (bus.cdb_tag == t);
        foreach (modelQ[i]) begin
            if (modelQ[i].tag == int'(t)) begin
                rdy = modelQ[i].ready || hit;
                dat = hit ? bus.cdb_data : modelQ[i].data;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        int          n;
        modelEntry_t h;
        logic        qr;
        logic [31:0] qd;
        n = modelQ.size();
        h = modelHead();
        checkVal({tag, ".count"},       32'(bus.count),       32'(n));
        checkVal({tag, ".alloc_ready"}, 32'(bus.alloc_ready), 32'(n != ROB_DEPTH));
        checkVal({tag, ".alloc_tag"},   32'(bus.alloc_tag),   32'(modelTail));
        checkVal({tag, ".empty"},       32'(bus.empty),       32'(n == 0));
        checkVal({tag, ".full"},        32'(bus.full),        32'(n == ROB_DEPTH));
        checkVal({tag, ".commit_load"}, 32'(bus.commit_load), 32'(h.ready));
        checkVal({tag, ".commit_dest"}, 32'(bus.commit_dest), 32'(h.rd));
        checkVal({tag, ".commit_data"}, bus.commit_data,      h.data);
        checkVal({tag, ".commit_tag"},  32'(bus.commit_tag),  32'(h.tag));
        modelQuery(bus.query_tag_a, qr, qd);
        checkVal({tag, ".query_ready_a"}, 32'(bus.query_ready_a), 32'(qr));
        if (qr) checkVal({tag, ".query_data_a"}, bus.query_data_a, qd);
        modelQuery(bus.query_tag_b, qr, qd);
        checkVal({tag, ".query_ready_b"}, 32'(bus.query_ready_b), 32'(qr));
        if (qr) checkVal({tag, ".query_data_b"}, bus.query_data_b, qd);
    endtask

    task automatic modelAdvance();
        int          n;
        bit          commitNow;
        n = modelQ.size();
        if (bus.flush) begin
            modelQ.delete();
            modelTail = 0;
        end else begin
            commitNow = (n > 0) && modelQ[0].ready;
            if (bus.cdb_valid) begin
                foreach (modelQ[i]) begin
                    if (modelQ[i].tag == int'(bus.cdb_tag) && !(commitNow && i == 0)) begin
                        modelQ[i].ready = 1'b1;
                        modelQ[i].data  = bus.cdb_data;
                    end
                end
            end
            if (commitNow) void'(modelQ.pop_front());
            if (bus.alloc_req && n < ROB_DEPTH) begin
                modelQ.push_back('{tag: modelTail, rd: bus.alloc_rd, ready: 1'b0, data: 32'd0});
                modelTail = (modelTail + 1) % ROB_DEPTH;
            end
        end
    endtask

    task automatic finishCycle(input string tag);
        checkOutput(tag);
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        finishCycle(tag);
    endtask

    task automatic randomStep();
        logic       fl;
        logic [2:0] ct;
        int         n;
        n  = modelQ.size();
        fl = ($urandom_range(0, 39) == 0);
        if (n > 0 && modelQ[0].ready) fl = 1'b0;
        ct = 3'($urandom_range(0, 7));
        if (n > 0 && $urandom_range(0, 3) != 0) ct = 3'(modelQ[$urandom_range(0, n - 1)].tag);
        applyStimulus(fl, 1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 9) < 6), ct, $urandom,
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        modelQ.delete();
        modelTail = 0;

        // Reset state
        @(negedge clk);
        checkVal("reset.alloc_ready",   32'(bus.alloc_ready),   32'd1);
        checkVal("reset.alloc_tag",     32'(bus.alloc_tag),     32'd0);
        checkVal("reset.empty",         32'(bus.empty),         32'd1);
        checkVal("reset.full",          32'(bus.full),          32'd0);
        checkVal("reset.commit_load",   32'(bus.commit_load),   32'd0);
        checkVal("reset.commit_dest",   32'(bus.commit_dest),   32'd0);
        checkVal("reset.commit_data",   bus.commit_data,        32'd0);
        checkVal("reset.query_ready_a", 32'(bus.query_ready_a), 32'd0);
        checkVal("reset.query_ready_b", 32'(bus.query_ready_b), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Allocate rd 5,6,7
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 5'(5 + k), 1'b0, 3'd0, 32'd0, 3'd0, 3'd1);
            @(negedge clk);
            checkVal("alloc.tag", 32'(bus.alloc_tag), 32'(k));
            finishCycle("alloc");
        end
        idle();
        @(negedge clk);
        checkVal("alloc3.count", 32'(bus.count), 32'd3);
        checkVal("alloc3.commit_load", 32'(bus.commit_load), 32'd0);
        finishCycle("alloc3");

        // Out-of-order completion, then in-order retirement
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 3'd1, 32'hAAAA_0001, 3'd1, 3'd0);
        cycle("cdb1");
        idle();
        @(negedge clk);
        checkVal("ooo.commit_load", 32'(bus.commit_load), 32'd0);
        finishCycle("ooo");
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 3'd0, 32'h0000_1234, 3'd0, 3'd1);
        cycle("cdb0");
        idle();
        @(negedge clk);
        checkVal("commit0.load", 32'(bus.commit_load), 32'd1);
        checkVal("commit0.dest", 32'(bus.commit_dest), 32'd5);
        checkVal("commit0.data", bus.commit_data, 32'h0000_1234);
        finishCycle("commit0");
        idle();
        @(negedge clk);
        checkVal("commit1.load", 32'(bus.commit_load), 32'd1);
        checkVal("commit1.dest", 32'(bus.commit_dest), 32'd6);
        checkVal("commit1.data", bus.commit_data, 32'hAAAA_0001);
        finishCycle("commit1");

        // Flush with concurrent CDB and allocate; head is not ready
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 5'(10 + k), 1'b0, 3'd0, 32'd0, 3'd3, 3'd4);
            cycle("preflush");
        end
        idle();
        @(negedge clk);
        checkVal("preflush.count", 32'(bus.count), 32'd4);
        finishCycle("preflush4");
        applyStimulus(1'b1, 1'b1, 5'd9, 1'b1, 3'd3, 32'h5555_5555, 3'd3, 3'd2);
        cycle("flush");
        idle();
        @(negedge clk);
        checkVal("postflush.count",       32'(bus.count),       32'd0);
        checkVal("postflush.empty",       32'(bus.empty),       32'd1);
        checkVal("postflush.alloc_tag",   32'(bus.alloc_tag),   32'd0);
        checkVal("postflush.commit_load", 32'(bus.commit_load), 32'd0);
        finishCycle("postflush");

        // Fill to full and exercise the wrap
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 5'(k + 1), 1'b0, 3'd0, 32'd0, 3'd0, 3'd7);
            cycle("fill");
        end
        applyStimulus(1'b0, 1'b1, 5'd20, 1'b0, 3'd0, 32'd0, 3'd0, 3'd7);
        @(negedge clk);
        checkVal("full.full",        32'(bus.full),        32'd1);
        checkVal("full.alloc_ready", 32'(bus.alloc_ready), 32'd0);
        finishCycle("fullIgnored");
        applyStimulus(1'b0, 1'b1, 5'd21, 1'b1, 3'd0, 32'hCAFE_0000, 3'd0, 3'd7);
        @(negedge clk);
        checkVal("full.tail", 32'(bus.alloc_tag), 32'd0);
        finishCycle("fullCdb");
        applyStimulus(1'b0, 1'b1, 5'd22, 1'b0, 3'd0, 32'd0, 3'd0, 3'd7);
        @(negedge clk);
        checkVal("commitFull.load",        32'(bus.commit_load), 32'd1);
        checkVal("commitFull.alloc_ready", 32'(bus.alloc_ready), 32'd0);
        finishCycle("commitFull");
        applyStimulus(1'b0, 1'b1, 5'd23, 1'b0, 3'd0, 32'd0, 3'd0, 3'd7);
        @(negedge clk);
        checkVal("wrap.count",     32'(bus.count),     32'd7);
        checkVal("wrap.alloc_tag", 32'(bus.alloc_tag), 32'd0);
        finishCycle("wrap");
        idle();
        @(negedge clk);
        checkVal("refill.count", 32'(bus.count), 32'd8);
        finishCycle("refill");

        // Same-cycle CDB forwarding on the query port
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 3'd2, 32'h0000_DEAD, 3'd2, 3'd3);
        @(negedge clk);
        checkVal("fwd.query_ready_a", 32'(bus.query_ready_a), 32'd1);
        checkVal("fwd.query_data_a",  bus.query_data_a,       32'h0000_DEAD);
        finishCycle("fwd");

        // Asynchronous reset mid-cycle with three entries in flight
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd1);
        cycle("flush2");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 5'(k + 3), 1'b0, 3'd0, 32'd0, 3'd0, 3'd1);
            cycle("alloc3b");
        end
        idle();
        #2;
        checkVal("prereset.count", 32'(bus.count), 32'd3);
        rst = 1'b1;
        #1;
        checkVal("asyncReset.count",       32'(bus.count),       32'd0);
        checkVal("asyncReset.empty",       32'(bus.empty),       32'd1);
        checkVal("asyncReset.alloc_ready", 32'(bus.alloc_ready), 32'd1);
        checkVal("asyncReset.alloc_tag",   32'(bus.alloc_tag),   32'd0);
        checkVal("asyncReset.commit_dest", 32'(bus.commit_dest), 32'd0);
        checkVal("asyncReset.query_ready", 32'(bus.query_ready_a), 32'd0);
        modelQ.delete();
        modelTail = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic against the queue model
        for (int k = 0; k < 400; k++) begin
            randomStep();
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
